// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle radix-2 restoring divider. It produces one quotient bit per
// clock and reports the quotient Q and remainder R with a one-cycle done
// pulse. It uses the same start/done handshake as the sequential Booth
// multiplier, so one controller can drive both blocks.
//
// Compile-time option:
//   DIV_SIGNED_EN - when defined, operands and results are two's-complement
//                   signed. Division truncates toward zero, R takes the sign
//                   of A, and most-negative / -1 wraps to most-negative.
//                   When undefined, operands and results are unsigned.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   A      in   [WIDTH] dividend, captured with start
//   B      in   [WIDTH] divisor, captured with start
//   busy   out  high from start acceptance until the done cycle
//   done   out  one-cycle pulse; Q, R and dz are valid from this cycle
//   Q      out  [WIDTH] quotient (all ones on divide-by-zero)
//   R      out  [WIDTH] remainder (A unchanged on divide-by-zero)
//   dz     out  divide-by-zero flag for the last result
//
// Timing: start accepted at edge E0 -> done high after edge E0+WIDTH+1.
// A divide-by-zero skips the iterations, so done is high after edge E0+1.
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             dz
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] dvd_reg;    // dividend magnitude; quotient bits shift in at the LSB
   logic [WIDTH-1:0] dvs_reg;    // divisor magnitude
   logic [WIDTH-1:0] rem_reg;    // partial remainder; always below dvs_reg
   logic [WIDTH-1:0] a_reg;      // raw dividend, returned as R on divide-by-zero
   logic [CW-1:0]    cnt_reg;
   logic             zero_reg;
`ifdef DIV_SIGNED_EN
   logic             neg_q_reg;
   logic             neg_r_reg;
`endif

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
`ifdef DIV_SIGNED_EN
      // Negating the most-negative value gives the same bit pattern. Read as
      // unsigned, that is its correct magnitude 2**(WIDTH-1).
      abs_a = A[WIDTH-1] ? -A : A;
      abs_b = B[WIDTH-1] ? -B : B;
`else
      abs_a = A;
      abs_b = B;
`endif
      // The working remainder is WIDTH+1 bits wide. Bit WIDTH of trial is the
      // borrow that decides whether the subtraction is kept or restored.
      shifted = {rem_reg, dvd_reg[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_reg};

      if (zero_reg) begin
         q_fix = '1;
         r_fix = a_reg;
      end else begin
`ifdef DIV_SIGNED_EN
         q_fix = neg_q_reg ? -dvd_reg : dvd_reg;
         r_fix = neg_r_reg ? -rem_reg : rem_reg;
`else
         q_fix = dvd_reg;
         r_fix = rem_reg;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         dvd_reg   <= '0;
         dvs_reg   <= '0;
         rem_reg   <= '0;
         a_reg     <= '0;
         cnt_reg   <= '0;
         zero_reg  <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
`endif
         busy      <= 1'b0;
         done      <= 1'b0;
         Q         <= '0;
         R         <= '0;
         dz        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  dvd_reg   <= abs_a;
                  dvs_reg   <= abs_b;
                  a_reg     <= A;
                  rem_reg   <= '0;
                  cnt_reg   <= '0;
                  zero_reg  <= (B == '0);
`ifdef DIV_SIGNED_EN
                  neg_q_reg <= A[WIDTH-1] ^ B[WIDTH-1];
                  neg_r_reg <= A[WIDTH-1];
`endif
                  busy      <= 1'b1;
                  state_reg <= (B == '0) ? FIX : CALC;
               end
            end
            CALC: begin
               if (!trial[WIDTH]) begin
                  rem_reg <= trial[WIDTH-1:0];
                  dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b1};
               end else begin
                  // On restore, shifted is below the divisor, so its top bit is zero.
                  rem_reg <= shifted[WIDTH-1:0];
                  dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
               end
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  state_reg <= FIX;
               end
            end
            FIX: begin
               Q         <= q_fix;
               R         <= r_fix;
               dz        <= zero_reg;
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Bench for seq_divider with WIDTH=8. A reference model works out each
// result with plain integer division. It also tracks timing as an
// accept-then-countdown process. One compare process checks busy, done, Q,
// R and dz against the model on every falling edge. Directed operations
// check hand-computed literals. A randomized phase drives start, A and B
// freely, including while the divider is busy.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] Q;
   logic [W-1:0] R;
   logic         dz;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Model state
   bit           m_busy = 0;
   bit           m_done = 0;
   int           m_left = 0;
   logic [W-1:0] m_q    = '0;
   logic [W-1:0] m_r    = '0;
   logic         m_dz   = 1'b0;
   logic [W-1:0] p_q    = '0;
   logic [W-1:0] p_r    = '0;
   logic         p_dz   = 1'b0;
   bit           was_busy;

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R),
      .dz    (dz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference division from the arithmetic rules alone.
   task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      longint sa;
      longint sb;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = longint'($signed(a));
         sb = longint'($signed(b));
`else
         sa = longint'({56'd0, a});
         sb = longint'({56'd0, b});
`endif
         q = W'(sa / sb);
         r = W'(sa % sb);
         z = 1'b0;
      end
   endtask

   // Timing model: an accepted request completes WIDTH+1 edges later, or one
   // edge later for a zero divisor. A request is ignored while one is pending.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_done = 0; m_left = 0;
            m_q = '0; m_r = '0; m_dz = 1'b0;
         end else begin
            was_busy = m_busy;
            m_done   = 0;
            if (m_busy) begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 0;
                  m_done = 1;
                  m_q = p_q; m_r = p_r; m_dz = p_dz;
               end
            end
            if (!was_busy && start) begin
               ref_div(A, B, p_q, p_r, p_dz);
               m_busy = 1;
               m_left = p_dz ? 1 : W + 1;
            end
         end
      end
   end

   // Compare process
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("Q",    32'(Q),    32'(m_q));
            check("R",    32'(R),    32'(m_r));
            check("dz",   32'(dz),   32'(m_dz));
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
   endtask

   // Call this at #1 after E0. It waits a bounded time for done and checks
   // the latency and the result.
   task automatic finish_op(input string name, input int exp_lat,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
      int lat;
      bit seen;
      lat = 0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) seen = 1;
      end
      check({name, "_timeout"}, 32'(seen), 32'd1);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_Q"}, 32'(Q), 32'(eq));
      check({name, "_R"}, 32'(R), 32'(er));
      check({name, "_dz"}, 32'(dz), 32'(edz));
      $display("op %s: Q=0x%0h R=0x%0h dz=%0d latency=%0d", name, Q, R, dz, lat);
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return W'(8'h80);
         3:       return W'(8'h7F);
         4:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   logic [W-1:0] tq;
   logic [W-1:0] tr;
   logic         tz;
   int           npulse;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;

      // Pin the reference model with hand-computed values.
      ref_div(W'(100), W'(7), tq, tr, tz);
      check("model_100_7", {tq, tr, 7'd0, tz}, {8'd14, 8'd2, 7'd0, 1'b0});
      ref_div(W'(5), W'(0), tq, tr, tz);
      check("model_5_0", {tq, tr, 7'd0, tz}, {8'hFF, 8'd5, 7'd0, 1'b1});
`ifdef DIV_SIGNED_EN
      ref_div(W'(8'h9C), W'(7), tq, tr, tz);
      check("model_m100_7", {tq, tr}, {8'hF2, 8'hFE});
      ref_div(W'(8'h80), W'(8'hFF), tq, tr, tz);
      check("model_ovf", {tq, tr, 7'd0, tz}, {8'h80, 8'h00, 7'd0, 1'b0});
`else
      ref_div(W'(200), W'(7), tq, tr, tz);
      check("model_200_7", {tq, tr}, {8'd28, 8'd4});
      ref_div(W'(8'h9C), W'(7), tq, tr, tz);
      check("model_156_7", {tq, tr}, {8'd22, 8'd2});
`endif

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_QRdz", {Q, R, 7'd0, dz}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1;

      // Directed operations
      issue(W'(100), W'(7));  finish_op("100/7", W + 1, W'(14), W'(2), 1'b0);
      issue(W'(5), W'(0));    finish_op("5/0", 1, W'(8'hFF), W'(5), 1'b1);
`ifdef DIV_SIGNED_EN
      issue(W'(8'h9C), W'(7));    finish_op("-100/7", W + 1, W'(8'hF2), W'(8'hFE), 1'b0);
      issue(W'(100), W'(8'hF9));  finish_op("100/-7", W + 1, W'(8'hF2), W'(8'h02), 1'b0);
      issue(W'(8'h80), W'(8'hFF)); finish_op("ovf", W + 1, W'(8'h80), W'(8'h00), 1'b0);
`else
      issue(W'(200), W'(7));  finish_op("200/7", W + 1, W'(28), W'(4), 1'b0);
      issue(W'(255), W'(1));  finish_op("255/1", W + 1, W'(255), W'(0), 1'b0);
`endif

      // A start while busy is ignored, and the next start is accepted at E0+W+2.
      issue(W'(100), W'(7));          // E0
      @(posedge clk);                 // E1
      @(posedge clk);                 // E2
      @(negedge clk);
      A = W'(50); B = W'(3); start = 1'b1;
      @(posedge clk);                 // E3
      #1 start = 1'b0;
      npulse = 0;
      for (int k = 4; k <= W + 1; k++) begin
         @(posedge clk);
         #1;
         if (done) npulse++;
      end
      check("ign_pulses", 32'(npulse), 32'd1);
      check("ign_Q", 32'(Q), 32'd14);
      check("ign_R", 32'(R), 32'd2);
      $display("op ignore-start: pulses=%0d Q=0x%0h R=0x%0h", npulse, Q, R);
      A = W'(64); B = W'(5); start = 1'b1;
      @(posedge clk);                 // E0+W+2
      #1 start = 1'b0;
      check("next_busy", 32'(busy), 32'd1);
      finish_op("64/5", W + 1, W'(12), W'(4), 1'b0);

      // A reset in the middle of an operation aborts it.
      issue(W'(77), W'(3));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_QRdz", {Q, R, 7'd0, dz}, 32'd0);
      npulse = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) npulse++;
      end
      #2 rst_n = 1'b1;
      repeat (2 * W) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check("abort_no_done", 32'(npulse), 32'd0);
      $display("op reset-abort: done pulses after abort=%0d", npulse);
      issue(W'(9), W'(3));  finish_op("9/3", W + 1, W'(3), W'(0), 1'b0);

      // Randomized traffic. The compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         A = rand_operand();
         B = rand_operand();
         if (done) $display("rand done: Q=0x%0h R=0x%0h dz=%0d", Q, R, dz);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (W + 4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle radix-2 restoring divider, the inverse-operation companion to the team's sequential Booth multiplier. Takes a dividend A and divisor B, iterates one quotient bit per clock, and returns quotient Q and remainder R with a one-cycle done pulse. Sits beside the multiplier in the arithmetic datapath and uses the same start/done style, so both can be driven by one controller.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (legal range 2..32).

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
A  input  WIDTH  dividend; sampled with start.
B  input  WIDTH  divisor; sampled with start.
busy  output  1  high from start acceptance until the done cycle.
done  output  1  one-cycle pulse; Q, R and dz are valid from this cycle.
Q  output  WIDTH  quotient.
R  output  WIDTH  remainder.
dz  output  1  divide-by-zero flag for the last result.

Behaviour:
- Reset: busy=0, done=0, Q=0, R=0, dz=0, state=IDLE, iteration counter=0. Asserting reset mid-operation aborts the operation immediately; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - capture |A|, |B| (unsigned WIDTH bits) and the sign bits;
  - clear partial remainder (WIDTH+1 bits) and counter;
  - busy<=1;
  - go to CALC, or to FIX directly if B==0.
- CALC, one iteration per edge:
  - shift {rem, dividend} left by one;
  - trial = rem - |B|;
  - if trial is non-negative, rem<=trial and the quotient bit is 1, else the quotient bit is 0;
  - after WIDTH iterations (counter==WIDTH-1), go to FIX.
- FIX, one edge:
  - register Q and R;
  - done<=1, busy<=0, go to IDLE;
  - done drops on the next edge.
- Latency: done is high in the cycle after edge E0+WIDTH+1. The next start is accepted at edge E0+WIDTH+2, so one start may be accepted every WIDTH+2 cycles. For divide-by-zero, done is high after edge E0+1.
- Signed rules (truncation toward zero):
  - Q is negated if sign(A) xor sign(B);
  - R takes the sign of A;
  - invariant A == Q*B + R, with |R| < |B|.
- Overflow: most-negative / -1 returns Q = most-negative (wraps, 0x80 for WIDTH=8), R=0, dz=0.
- Divide-by-zero: Q = all ones, R = A unchanged, dz=1.
- start while busy is ignored; it is not queued.
- Q, R and dz hold their values until the next FIX edge.
- A and B may change after the E0 edge without affecting the result.

Optional Feature:
DIV_SIGNED_EN
- Defined: operands and results are two's-complement signed, with the sign rules and overflow case above.
- Undefined:
  - operands are unsigned, with no abs or sign-fix logic;
  - FIX only registers the result, with the same latency;
  - divide-by-zero gives Q = all ones, R = A, dz=1.

Test Plan:
- WIDTH=8, signed: A=100, B=7, start at E0 -> done high after edge E0+9; Q=14, R=2, dz=0.
- Signed: A=-100 (0x9C), B=7 -> Q=0xF2 (-14), R=0xFE (-2). Then A=100, B=-7 -> Q=0xF2, R=2.
- Signed: A=0x80, B=0xFF -> Q=0x80, R=0x00, dz=0. Then A=5, B=0 -> done after edge E0+1; Q=0xFF, R=5, dz=1.
- Unsigned build (macro undefined): A=200, B=7 -> Q=28, R=4. Then A=255, B=1 -> Q=255, R=0.
- Start pulsed again at E0+3 with different operands -> ignored: exactly one done pulse, for the original operands. A new start at E0+WIDTH+2 is accepted.
- rst_n low at E0+4 -> busy, done, Q, R and dz go to 0 immediately; no done pulse follows. After release, A=9, B=3 -> Q=3, R=0.
